// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result/flag bundle for alu_seq.
//   master : drives start, a, b, op; receives result, done, busy, flags
//   slave  : the ALU side of the same signals
interface alu_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [N-1:0] result;
    logic         done;
    logic         busy;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    modport master (
        output start, a, b, op,
        input  result, done, busy, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  start, a, b, op,
        output result, done, busy, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with start/done handshake and N/Z/C/V flags.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR) write result on the
// accepting edge; MUL is an iterative shift-add taking N further edges.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : alu_seq_if slave -- start/a/b/op in, result/done/busy/flags out
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; single-cycle ops complete here
// S_MUL  | shift-add multiply in progress, busy high, start ignored
module alu_seq #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus
);
    localparam int CW = (SW < 1) ? 1 : SW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t         state;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] prod;
    logic [CW-1:0]  cnt;

    logic [N:0]     sum_add;
    logic [N:0]     sum_sub;
    logic [N:0]     shl_full;
    logic [N:0]     shr_full;
    logic [SW-1:0]  amt;
    logic [N-1:0]   sc_res;
    logic           sc_c;
    logic           sc_v;
    logic [2*N-1:0] prod_next;

    assign amt     = bus.b[SW-1:0];
    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};
    // Top bit of the N+1-bit difference is the borrow (a < b unsigned).
    assign sum_sub = {1'b0, bus.a} - {1'b0, bus.b};
    // One guard bit catches the last bit shifted out; it stays 0 for amount 0.
    assign shl_full = {1'b0, bus.a} << amt;
    assign shr_full = {bus.a, 1'b0} >> amt;

    assign prod_next = prod + (mplier[0] ? mcand : '0);

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_res = sum_add[N-1:0];
                sc_c   = sum_add[N];
                sc_v   = (bus.a[N-1] == bus.b[N-1]) && (sum_add[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                sc_res = sum_sub[N-1:0];
                sc_c   = sum_sub[N];
                sc_v   = (bus.a[N-1] ^ bus.b[N-1]) & (bus.a[N-1] ^ sum_sub[N-1]);
            end
            OP_AND: sc_res = bus.a & bus.b;
            OP_OR:  sc_res = bus.a | bus.b;
            OP_XOR: sc_res = bus.a ^ bus.b;
            OP_SHL: begin
                sc_res = shl_full[N-1:0];
                sc_c   = shl_full[N];
            end
            OP_SHR: begin
                sc_res = shr_full[N:1];
                sc_c   = shr_full[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mcand      <= '0;
            mplier     <= '0;
            prod       <= '0;
            cnt        <= '0;
            bus.result <= '0;
            bus.done   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.flag_n <= 1'b0;
            bus.flag_z <= 1'b0;
            bus.flag_c <= 1'b0;
            bus.flag_v <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            mcand    <= {{N{1'b0}}, bus.a};
                            mplier   <= bus.b;
                            prod     <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= S_MUL;
                        end else begin
                            bus.result <= sc_res;
                            bus.flag_n <= sc_res[N-1];
                            bus.flag_z <= (sc_res == '0);
                            bus.flag_c <= sc_c;
                            bus.flag_v <= sc_v;
                            bus.done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) begin
                        bus.result <= prod_next[N-1:0];
                        bus.flag_n <= prod_next[N-1];
                        bus.flag_z <= (prod_next[N-1:0] == '0);
                        bus.flag_c <= (prod_next[2*N-1:N] != '0);
                        bus.flag_v <= (prod_next[2*N-1:N] != '0);
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int N = 8;

    typedef struct packed {
        logic [7:0] r;
        logic       n;
        logic       z;
        logic       c;
        logic       v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    alu_seq_if #(.N(N)) bus ();
    alu_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: plain integer arithmetic over the opcode rules.
    function automatic res_t model(input int o, input int x, input int y);
        res_t m;
        int   s;
        int   sh;
        m = '0;
        s = 0;
        sh = y % 8;
        case (o)
            0: begin
                s = x + y;
                m.c = (s > 255);
                m.v = ((x >= 128) == (y >= 128)) && (((s & 255) >= 128) != (x >= 128));
            end
            1: begin
                s = x - y;
                m.c = (x < y);
                m.v = ((x >= 128) != (y >= 128)) && (((s & 255) >= 128) != (x >= 128));
            end
            2: s = x & y;
            3: s = x | y;
            4: s = x ^ y;
            5: begin
                s = x << sh;
                m.c = (sh != 0) && (((s >> 8) & 1) == 1);
            end
            6: begin
                s = x >> sh;
                m.c = (sh != 0) && (((x >> (sh - 1)) & 1) == 1);
            end
            default: begin
                s = x * y;
                m.c = ((s >> 8) != 0);
                m.v = m.c;
            end
        endcase
        m.r = 8'(s & 255);
        m.n = m.r[7];
        m.z = (m.r == 8'h00);
        return m;
    endfunction

    function automatic res_t observed();
        return {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
    endfunction

    // Present one request for exactly one edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({observed(), bus.done, bus.busy} !== 14'h0)
            $display("FAIL reset_state got=%h busy=%b done=%b exp=all zero", observed(), bus.busy, bus.done);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0] d_op  [7] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd5, 3'd6, 3'd5};
        logic [7:0] d_a   [7] = '{8'h7F, 8'hFF, 8'h00, 8'h80, 8'h81, 8'h81, 8'hA5};
        logic [7:0] d_b   [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h07, 8'h00};
        res_t       d_exp [7] = '{{8'h80, 4'b1001}, {8'h00, 4'b0110}, {8'hFF, 4'b1010},
                                  {8'h7F, 4'b0001}, {8'h02, 4'b0010}, {8'h01, 4'b0000},
                                  {8'hA5, 4'b1000}};
        for (int i = 0; i < 7; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            n_checks++;
            if (bus.done !== 1'b1 || observed() !== d_exp[i])
                $display("FAIL directed[%0d] got=%h done=%b exp=%h done=1", i, observed(), bus.done, d_exp[i]);
            else
                n_pass++;
            // Inputs move without start: result/flags must hold, done must drop.
            @(negedge clk);
            bus.a  = 8'h00;
            bus.b  = 8'h00;
            bus.op = 3'd3;
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b0 || observed() !== d_exp[i])
                $display("FAIL hold[%0d] got=%h done=%b exp=%h done=0", i, observed(), bus.done, d_exp[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_random_single();
        int   o, x, y;
        res_t e;
        for (int i = 0; i < 40; i++) begin
            o = $urandom_range(0, 6);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            e = model(o, x, y);
            issue(3'(o), 8'(x), 8'(y));
            n_checks++;
            if (bus.done !== 1'b1 || observed() !== e)
                $display("FAIL random_op%0d a=%h b=%h got=%h done=%b exp=%h", o, x, y, observed(), bus.done, e);
            else
                n_pass++;
        end
    endtask

    task automatic test_mul(input int x, input int y);
        res_t e;
        int   edges;
        int   busy_cnt;
        e = model(7, x, y);
        issue(3'd7, 8'(x), 8'(y));
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL mul_accept busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done);
        else
            n_pass++;
        edges = 0;
        busy_cnt = 1;
        for (int k = 1; k <= N + 4 && bus.done !== 1'b1; k++) begin
            // Start pulses and operand churn while busy must be ignored.
            @(negedge clk);
            bus.start = (k >= 2 && k <= 4);
            bus.op    = 3'($urandom_range(0, 7));
            bus.a     = 8'($urandom_range(0, 255));
            bus.b     = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            edges = k;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || edges != N || bus.busy !== 1'b0)
            $display("FAIL mul_latency a=%h b=%h done=%b edges=%0d busy=%b exp done=1 edges=%0d busy=0",
                     x, y, bus.done, edges, bus.busy, N);
        else
            n_pass++;
        n_checks++;
        if (busy_cnt != N)
            $display("FAIL mul_busy_cycles got=%0d exp=%0d", busy_cnt, N);
        else
            n_pass++;
        n_checks++;
        if (observed() !== e)
            $display("FAIL mul_result a=%h b=%h got=%h exp=%h", x, y, observed(), e);
        else
            n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL mul_single_done cycle%0d done=%b busy=%b exp 0 0", k, bus.done, bus.busy);
            else
                n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [3] = '{3'd2, 3'd3, 3'd4};
        logic [7:0] exps [3] = '{8'h30, 8'hFC, 8'hCC};
        int   o, x, y;
        res_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hF0;
        bus.b     = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            bus.op = ops[i];
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b1 || bus.result !== exps[i])
                $display("FAIL b2b_logic[%0d] got=%h done=%b exp=%h done=1", i, bus.result, bus.done, exps[i]);
            else
                n_pass++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            o = $urandom_range(0, 6);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            e = model(o, x, y);
            bus.op = 3'(o);
            bus.a  = 8'(x);
            bus.b  = 8'(y);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b1 || observed() !== e)
                $display("FAIL b2b_random[%0d] op%0d got=%h done=%b exp=%h", i, o, observed(), bus.done, e);
            else
                n_pass++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        issue(3'd0, 8'h7F, 8'h01);
        issue(3'd7, 8'h0F, 8'h11);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({observed(), bus.done, bus.busy} !== 14'h0)
            $display("FAIL reset_mid_mul got=%h done=%b busy=%b exp all zero", observed(), bus.done, bus.busy);
        else
            n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL reset_no_done cycle%0d done=%b busy=%b exp 0 0", k, bus.done, bus.busy);
            else
                n_pass++;
        end
        issue(3'd0, 8'h02, 8'h03);
        n_checks++;
        if (bus.done !== 1'b1 || observed() !== {8'h05, 4'b0000})
            $display("FAIL add_after_reset got=%h done=%b exp=050 done=1", observed(), bus.done);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_single();
        test_mul(8'h0F, 8'h11);
        test_mul(8'h10, 8'h10);
        for (int i = 0; i < 4; i++)
            test_mul($urandom_range(0, 255), $urandom_range(0, 255));
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
